// File: rtl/speed_timer.sv
// Speed-selectable timeout generator: counts prescaler ticks and pulses timeout every N ticks,
// where N comes from a speed table or an override. Supports periodic/one-shot, pause and clear.
module speed_timer #(
    parameter int CNT_W       = 8,
    parameter int SPD_W       = 3,
    parameter int BASE_PERIOD = 15,
    parameter int STEP        = 2,
    parameter int MIN_PERIOD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             tick,
    input  logic [SPD_W-1:0] speed,
    input  logic             mode,
    input  logic             ovr_en,
    input  logic [CNT_W-1:0] ovr_period,
    output logic             timeout,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Table arithmetic is done wide and signed so large speed*STEP products go negative, not wrap.
    localparam int CW = CNT_W + SPD_W + 1;
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] RST_PERIOD = (BASE_PERIOD < MIN_PERIOD) ? MIN_P
                                                                          : CNT_W'(BASE_PERIOD);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   next_period;
    logic signed [CW-1:0] table_s;
    logic               last_tick;

    always_comb begin
        table_s     = CW'(BASE_PERIOD) - CW'(speed) * CW'(STEP);
        next_period = MIN_P;
        if (ovr_en) begin
            if (ovr_period >= MIN_P) begin
                next_period = ovr_period;
            end
        end else if (table_s >= signed'(CW'(MIN_PERIOD))) begin
            next_period = table_s[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        timeout_d = 1'b0;
        last_tick = (count_q == period_q - CNT_W'(1));
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (enable) begin
                    state_d  = S_RUN;
                    period_d = next_period;
                end
            end
            S_RUN: begin
                // clear wins over a coincident tick: no advance, no expiry
                if (clear) begin
                    count_d  = '0;
                    period_d = next_period;
                end else if (tick) begin
                    if (last_tick) begin
                        count_d   = '0;
                        timeout_d = 1'b1;
                        period_d  = next_period;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (!clear && tick && last_tick && mode) begin
                    state_d = S_DONE;
                end else if (!enable) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    count_d  = '0;
                    period_d = next_period;
                end
                if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                count_d = '0;
                if (clear) begin
                    if (enable) begin
                        state_d  = S_RUN;
                        period_d = next_period;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            period_q  <= RST_PERIOD;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q == S_RUN);
    assign count   = count_q;
    assign period  = period_q;

endmodule

// File: tb/tb_speed_timer.sv
// Directed bench for speed_timer: a cycle-level behavioural model is compared on every clock,
// with hand-computed literal checks at the interesting points of each scenario.
module tb_speed_timer;

    localparam int CNT_W = 8;
    localparam int SPD_W = 3;
    localparam int BASE  = 15;
    localparam int STEPV = 2;
    localparam int MINP  = 2;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             clear;
    logic             tick;
    logic [SPD_W-1:0] speed;
    logic             mode;
    logic             ovr_en;
    logic [CNT_W-1:0] ovr_period;
    logic             timeout;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period;

    speed_timer #(
        .CNT_W(CNT_W), .SPD_W(SPD_W), .BASE_PERIOD(BASE), .STEP(STEPV), .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .tick(tick),
        .speed(speed), .mode(mode), .ovr_en(ovr_en), .ovr_period(ovr_period),
        .timeout(timeout), .done(done), .busy(busy), .count(count), .period(period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  n_to  = 0;
    int  last_to_cyc = -1;
    int  to_spacing  = 0;
    bit  chk_on = 1'b0;

    // model state: a tick counter, the period in force, and which phase of a run we are in
    int  m_count   = 0;
    int  m_period  = BASE;
    bit  m_running = 1'b0;
    bit  m_paused  = 1'b0;
    bit  m_fin     = 1'b0;
    bit  m_timeout = 1'b0;

    function automatic int exp_period(input bit oe, input int ovr, input int spd);
        int p;
        p = oe ? ovr : BASE - spd * STEPV;
        if (p < MINP) p = MINP;
        return p;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        int c;
        int p;
        bit run;
        bit pau;
        bit fin;
        bit to;
        c = m_count; p = m_period; run = m_running; pau = m_paused; fin = m_fin; to = 1'b0;
        cyc <= cyc + 1;
        if (!rst) begin
            c = 0; p = exp_period(1'b0, 0, 0); run = 1'b0; pau = 1'b0; fin = 1'b0;
        end else if (fin) begin
            if (clear) begin
                fin = 1'b0;
                c = 0;
                if (enable) begin run = 1'b1; p = exp_period(ovr_en, ovr_period, speed); end
            end else if (!enable) begin
                fin = 1'b0;
            end
        end else if (pau) begin
            if (clear) begin c = 0; p = exp_period(ovr_en, ovr_period, speed); end
            if (enable) begin pau = 1'b0; run = 1'b1; end
        end else if (run) begin
            if (clear) begin
                c = 0; p = exp_period(ovr_en, ovr_period, speed);
            end else if (tick) begin
                c = c + 1;
                if (c == p) begin
                    c = 0; to = 1'b1; p = exp_period(ovr_en, ovr_period, speed);
                    if (mode) begin run = 1'b0; fin = 1'b1; end
                end
            end
            if (run && !enable) begin run = 1'b0; pau = 1'b1; end
        end else if (enable) begin
            run = 1'b1; p = exp_period(ovr_en, ovr_period, speed);
        end
        m_count <= c; m_period <= p; m_running <= run; m_paused <= pau;
        m_fin <= fin; m_timeout <= to;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("timeout", int'(timeout), int'(m_timeout));
            cmp("done",    int'(done),    int'(m_fin));
            cmp("busy",    int'(busy),    int'(m_running));
            cmp("count",   int'(count),   m_count);
            cmp("period",  int'(period),  m_period);
            if (timeout) begin
                n_to++;
                if (last_to_cyc >= 0) to_spacing = cyc - last_to_cyc;
                last_to_cyc = cyc;
            end
        end
    end

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        @(negedge clk);
    endtask

    int base;

    initial begin
        rst = 1'b0; enable = 1'b0; clear = 1'b0; tick = 1'b0; speed = '0;
        mode = 1'b0; ovr_en = 1'b0; ovr_period = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        cmp("rst_period", int'(period), 15);
        cmp("rst_count",  int'(count), 0);
        cmp("rst_busy",   int'(busy), 0);
        rst = 1'b1;

        // speed 0 periodic, tick every 4 clocks
        @(negedge clk); enable = 1'b1;
        do_ticks(30);
        cmp("spd0_timeouts", n_to, 2);
        cmp("spd0_spacing",  to_spacing, 60);
        cmp("spd0_period",   int'(period), 15);

        // speed 7 clamps to MIN_PERIOD
        speed = 3'd7;
        pulse_clear();
        cmp("spd7_period", int'(period), 2);
        base = n_to;
        do_ticks(6);
        cmp("spd7_timeouts", n_to - base, 3);

        // override period, zero clamps
        ovr_en = 1'b1; ovr_period = 8'd0;
        pulse_clear();
        cmp("ovr0_period", int'(period), 2);
        ovr_period = 8'd5;
        pulse_clear();
        cmp("ovr5_period", int'(period), 5);
        ovr_en = 1'b0;

        // speed change mid-period applies at the next boundary
        speed = 3'd0;
        pulse_clear();
        base = n_to;
        do_ticks(5);
        cmp("mid_count5", int'(count), 5);
        speed = 3'd3;
        do_ticks(9);
        cmp("mid_no_to", n_to - base, 0);
        cmp("mid_period_held", int'(period), 15);
        do_ticks(1);
        cmp("mid_to", n_to - base, 1);
        cmp("mid_new_period", int'(period), 9);

        // pause at count 7 for 20 ticks
        speed = 3'd0;
        pulse_clear();
        do_ticks(7);
        @(negedge clk); enable = 1'b0;
        repeat (2) @(negedge clk);
        base = n_to;
        do_ticks(20);
        cmp("pause_count", int'(count), 7);
        cmp("pause_no_to", n_to - base, 0);
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        do_ticks(7);
        cmp("resume_no_to", n_to - base, 0);
        do_ticks(1);
        cmp("resume_to", n_to - base, 1);

        // one-shot
        mode = 1'b1;
        base = n_to;
        do_ticks(15);
        cmp("os_to", n_to - base, 1);
        cmp("os_done", int'(done), 1);
        cmp("os_busy", int'(busy), 0);
        do_ticks(3);
        cmp("os_ignored", n_to - base, 1);
        @(negedge clk); enable = 1'b0;
        repeat (2) @(negedge clk);
        cmp("os_idle_done", int'(done), 0);

        // clear + tick together at count 14
        mode = 1'b0;
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        do_ticks(14);
        cmp("ct_count14", int'(count), 14);
        base = n_to;
        @(negedge clk); clear = 1'b1; tick = 1'b1;
        @(negedge clk); clear = 1'b0; tick = 1'b0;
        repeat (2) @(negedge clk);
        cmp("ct_count0", int'(count), 0);
        cmp("ct_no_to", n_to - base, 0);

        // enable falls with the final tick: expiry honoured, then pause
        do_ticks(14);
        base = n_to;
        @(negedge clk); tick = 1'b1; enable = 1'b0;
        @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        cmp("ef_to", n_to - base, 1);
        cmp("ef_busy", int'(busy), 0);
        cmp("ef_count", int'(count), 0);
        @(negedge clk); enable = 1'b1;

        // mid-period reset
        speed = 3'd3;
        do_ticks(3);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        cmp("mr_count",   int'(count), 0);
        cmp("mr_period",  int'(period), 15);
        cmp("mr_busy",    int'(busy), 0);
        cmp("mr_timeout", int'(timeout), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/speed_timer.md
Name: speed_timer

Overview:
- Parametrised speed-selectable timeout generator, successor to the fixed three-speed game-pace counter.
- Counts prescaler ticks (e.g. 100 ms strobe) and emits a one-clock timeout pulse every N ticks.
- N is derived from a speed level or a loaded override period.
- Adds periodic/one-shot modes, pause-and-resume, a synchronous clear, and glitch-free period changes. Sits between the prescaler and the game sequencing FSM.

Parameters:
- CNT_W, 8, width of tick counter and period values.
- SPD_W, 3, width of speed level input (2^SPD_W levels).
- BASE_PERIOD, 15, period in ticks at speed 0.
- STEP, 2, ticks removed per speed level.
- MIN_PERIOD, 2, floor on any computed or loaded period; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  run request; low pauses.
- clear  in  1  one-clock pulse; restart current period from zero.
- tick  in  1  one-clock prescaler strobe.
- speed  in  SPD_W  speed level.
- mode  in  1  0 = periodic, 1 = one-shot.
- ovr_en  in  1  1 = use ovr_period instead of the speed table.
- ovr_period  in  CNT_W  override period in ticks.
- timeout  out  1  one-clock pulse at period expiry.
- done  out  1  one-shot expired flag.
- busy  out  1  high in RUN.
- count  out  CNT_W  current tick count.
- period  out  CNT_W  period currently latched.

Behaviour:
- Reset (rst==0 at posedge clk): state IDLE; count=0, period=BASE_PERIOD clamped to MIN_PERIOD; timeout=0, done=0, busy=0. Reset overrides all other inputs.
- Period computation (next_period), combinational:
  - If ovr_en=1: next_period = ovr_period.
  - Else: next_period = BASE_PERIOD - speed*STEP, computed at width CNT_W+SPD_W+1 with signed/underflow-safe arithmetic.
  - Result clamped to MIN_PERIOD when below it, including zero and negative results.
- Period latching: period is loaded from next_period only on entry to RUN from IDLE/DONE, on clear, and at every expiry. Speed or override changes mid-period never alter the running period; they take effect at the next boundary.
- States:
  - IDLE: busy=0, count=0. On enable=1 go to RUN and latch period.
  - RUN: busy=1.
    - On tick: if count==period-1 then count<=0, timeout<=1 for exactly one clock, latch new period. In mode 1, go to DONE with done<=1. Otherwise count<=count+1.
    - If enable=0: go to PAUSE, count held.
  - PAUSE: busy=0; count and period held; ticks ignored. On enable=1 return to RUN and resume from the held count (no restart).
  - DONE: done=1, busy=0, count=0. Stays until enable=0, then goes to IDLE with done cleared.
- Latency: timeout is registered and asserted the clock after the tick that completes the period. Spacing between timeouts equals exactly period ticks.
- timeout is 0 in every cycle not described above. Two consecutive timeouts are impossible because period >= 1 and tick is a single-cycle strobe.
- clear:
  - In RUN or PAUSE: count<=0, period relatched, no timeout, state unchanged.
  - In DONE: count<=0, done<=0, go to RUN if enable=1, else IDLE.
  - In IDLE: no effect.
  - Priority: clear beats a simultaneous tick (no count advance, no timeout).
- enable falling in the same cycle as the final tick: the expiry is honoured (timeout pulses, count<=0), then the block enters PAUSE (periodic) or DONE (one-shot).
- count never exceeds period-1. Wrap is to zero only.
- A mid-operation reset aborts any period with no timeout pulse.

Test Plan:
- Speed 0, periodic, tick every 4 clocks, enable held -> timeout pulses each 15 ticks (60 clocks), one clock wide, period=15.
- Speed 7, BASE 15, STEP 2 -> computed value 1 is clamped, period=2; timeout every 2 ticks. ovr_en=1 with ovr_period=0 -> period=2.
- Change speed 0 to 3 at count=5 -> current period completes at 15 ticks; the next period is 9.
- Drop enable at count=7 for 20 ticks, then re-enable -> count stays 7, no timeout while paused; timeout after 8 more ticks.
- Mode 1 -> single timeout, then done=1 and busy=0 with further ticks ignored. Lowering enable returns to IDLE with done=0.
- clear and tick in the same cycle at count=14 of 15 -> no timeout, count=0. rst low mid-period -> all outputs are at their reset values next clock.
